// File: rtl/instr_fetch.sv
// Instruction fetch stage: host-loaded instruction RAM, program counter and IDLE/FETCH/EXEC/HALT sequencing.
// Optional macro INSTR_FETCH_COUNT_EN adds a saturating fetch_count output.
module instr_fetch #(
    parameter int unsigned INSTR_W = 16,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DEPTH   = 256
) (
    input  logic               clock,
    input  logic               rst,
    input  logic               load_we,
    input  logic [ADDR_W-1:0]  load_addr,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               start,
    input  logic               pc_inc,
    input  logic               pc_load,
    input  logic [ADDR_W-1:0]  jump_addr,
    input  logic               end_process,
    output logic [INSTR_W-1:0] instruction,
    output logic [1:0]         status,
    output logic [ADDR_W-1:0]  pc
`ifdef INSTR_FETCH_COUNT_EN
    ,
    output logic [15:0]        fetch_count
`endif
);

    localparam int unsigned RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = 16;

    // State encoding doubles as the status code, so status is simply the state register.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b11,
        ST_EXEC  = 2'b01,
        ST_HALT  = 2'b10
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [INSTR_W-1:0]  instr_q;
    logic [INSTR_W-1:0]  mem [DEPTH];
    logic                mem_we_c;
    logic                start_ok_c;
    logic                fetch_done_c;
    logic [RAM_AW-1:0]   rd_idx_c;
    logic [RAM_AW-1:0]   wr_idx_c;

    // Out-of-range addresses wrap modulo DEPTH.
    assign rd_idx_c = RAM_AW'(32'(pc_q) % DEPTH);
    assign wr_idx_c = RAM_AW'(32'(load_addr) % DEPTH);

    // Next-state and control decode.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        mem_we_c     = 1'b0;
        start_ok_c   = 1'b0;
        fetch_done_c = 1'b0;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (load_we) begin
                    mem_we_c = !rst;
                end else if (start) begin
                    pc_d       = '0;
                    state_d    = ST_FETCH;
                    start_ok_c = 1'b1;
                end
            end
            ST_FETCH: begin
                state_d      = ST_EXEC;
                fetch_done_c = 1'b1;
            end
            ST_EXEC: begin
                if (end_process) begin
                    state_d = ST_HALT;
                end else if (pc_load) begin
                    pc_d    = jump_addr;
                    state_d = ST_FETCH;
                end else if (pc_inc) begin
                    pc_d    = (pc_q == ADDR_W'(DEPTH - 1)) ? '0 : pc_q + ADDR_W'(1);
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (fetch_done_c) begin
                instr_q <= mem[rd_idx_c];
            end
        end
    end

    // RAM contents survive reset.
    always_ff @(posedge clock) begin
        if (mem_we_c) begin
            mem[wr_idx_c] <= load_data;
        end
    end

    assign instruction = instr_q;
    assign status      = state_q;
    assign pc          = pc_q;

`ifdef INSTR_FETCH_COUNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clock) begin
        if (rst || start_ok_c) begin
            cnt_q <= '0;
        end else if (fetch_done_c && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign fetch_count = cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch (honours INSTR_FETCH_COUNT_EN when defined).
module tb_instr_fetch;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned DEPTH   = 256;

    logic               clock = 1'b0;
    logic               rst;
    logic               load_we;
    logic [ADDR_W-1:0]  load_addr;
    logic [INSTR_W-1:0] load_data;
    logic               start;
    logic               pc_inc;
    logic               pc_load;
    logic [ADDR_W-1:0]  jump_addr;
    logic               end_process;
    logic [INSTR_W-1:0] instruction;
    logic [1:0]         status;
    logic [ADDR_W-1:0]  pc;
`ifdef INSTR_FETCH_COUNT_EN
    logic [15:0]        fetch_count;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    instr_fetch #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clock       (clock),
        .rst         (rst),
        .load_we     (load_we),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .start       (start),
        .pc_inc      (pc_inc),
        .pc_load     (pc_load),
        .jump_addr   (jump_addr),
        .end_process (end_process),
        .instruction (instruction),
        .status      (status),
        .pc          (pc)
`ifdef INSTR_FETCH_COUNT_EN
        ,
        .fetch_count (fetch_count)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input logic [ADDR_W-1:0] a, input logic [INSTR_W-1:0] d);
        load_we = 1'b1; load_addr = a; load_data = d;
        step();
        load_we = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [1:0] st, input logic [ADDR_W-1:0] p,
                              input logic [INSTR_W-1:0] ins);
        chk({tag, ".status"}, 32'(status), 32'(st));
        chk({tag, ".pc"}, 32'(pc), 32'(p));
        chk({tag, ".instr"}, 32'(instruction), 32'(ins));
    endtask

    logic [INSTR_W-1:0] prog [4];

    initial begin
        prog[0] = 16'd4101; prog[1] = 16'd4124; prog[2] = 16'd4141; prog[3] = 16'd61476;
        rst = 1'b1; load_we = 1'b0; load_addr = '0; load_data = '0; start = 1'b0;
        pc_inc = 1'b0; pc_load = 1'b0; jump_addr = '0; end_process = 1'b0;
        step();
        expect_out("reset", 2'b00, 8'd0, 16'd0);
`ifdef INSTR_FETCH_COUNT_EN
        chk("reset.count", 32'(fetch_count), 32'd0);
`endif
        rst = 1'b0;

        // Load program plus a word at the top address.
        for (int i = 0; i < 4; i++) load(ADDR_W'(i), prog[i]);
        load(8'd255, 16'h1234);
        expect_out("idle_after_load", 2'b00, 8'd0, 16'd0);

        // Load and run: 11 one edge after start, then 01 with mem[0].
        start = 1'b1; step(); start = 1'b0;
        expect_out("run.fetch", 2'b11, 8'd0, 16'd0);
        end_process = 1'b1;   // ignored while fetching
        step();
        end_process = 1'b0;
        expect_out("run.exec", 2'b01, 8'd0, 16'd4101);
        step(); step();
        expect_out("run.hold", 2'b01, 8'd0, 16'd4101);

        // Sequential stepping.
        for (int k = 1; k <= 3; k++) begin
            pc_inc = 1'b1; step(); pc_inc = 1'b0;
            expect_out("step.fetch", 2'b11, ADDR_W'(k), prog[k-1]);
            step();
            expect_out("step.exec", 2'b01, ADDR_W'(k), prog[k]);
        end

        // pc_load wins over pc_inc.
        pc_load = 1'b1; pc_inc = 1'b1; jump_addr = 8'd1; step();
        pc_load = 1'b0; pc_inc = 1'b0;
        expect_out("jump.fetch", 2'b11, 8'd1, 16'd61476);
        step();
        expect_out("jump.exec", 2'b01, 8'd1, 16'd4124);

        // end_process wins over pc_inc; HALT ignores requests but accepts writes.
        end_process = 1'b1; pc_inc = 1'b1; step();
        end_process = 1'b0; pc_inc = 1'b0;
        expect_out("halt", 2'b10, 8'd1, 16'd4124);
        load(8'd0, 16'd7);
        pc_inc = 1'b1; step(); pc_inc = 1'b0;
        expect_out("halt.hold", 2'b10, 8'd1, 16'd4124);
        start = 1'b1; step(); start = 1'b0;
        expect_out("rerun.fetch", 2'b11, 8'd0, 16'd4124);
        step();
        expect_out("rerun.exec", 2'b01, 8'd0, 16'd7);
`ifdef INSTR_FETCH_COUNT_EN
        chk("rerun.count", 32'(fetch_count), 32'd1);
`endif

        // Write during EXEC is ignored; jump to the top and wrap.
        load(8'd0, 16'd99);
        expect_out("exec.write", 2'b01, 8'd0, 16'd7);
        pc_load = 1'b1; jump_addr = 8'd255; step(); pc_load = 1'b0;
        step();
        expect_out("top.exec", 2'b01, 8'd255, 16'h1234);
        pc_inc = 1'b1; step(); pc_inc = 1'b0;
        chk("wrap.pc", 32'(pc), 32'd0);
        step();
        expect_out("wrap.exec", 2'b01, 8'd0, 16'd7);
`ifdef INSTR_FETCH_COUNT_EN
        chk("wrap.count", 32'(fetch_count), 32'd3);
`endif

        // Mid-run reset during FETCH.
        pc_inc = 1'b1; step(); pc_inc = 1'b0;
        chk("pre_rst.status", 32'(status), 32'd3);
        rst = 1'b1; step(); rst = 1'b0;
        expect_out("midrst", 2'b00, 8'd0, 16'd0);
`ifdef INSTR_FETCH_COUNT_EN
        chk("midrst.count", 32'(fetch_count), 32'd0);
`endif

        // start together with load_we in IDLE: the write wins, start ignored.
        start = 1'b1; load(8'd1, 16'd500); start = 1'b0;
        chk("start_we.status", 32'(status), 32'd0);
        start = 1'b1; step(); start = 1'b0;
        step();
        expect_out("after_rst.exec", 2'b01, 8'd0, 16'd7);
        pc_inc = 1'b1; step(); pc_inc = 1'b0;
        step();
        expect_out("after_rst.step", 2'b01, 8'd1, 16'd500);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
